// File: rtl/cpu_sequencer_if.sv
// Bus between the instruction sequencer and the datapath/memory port.
// The sequencer uses the master side; the datapath side drives opcode, zero and memAck.
interface cpu_sequencer_if;
  logic [3:0] opcode;
  logic       zero;
  logic       memAck;
  logic       memReq;
  logic       memWe;
  logic       addrSel;
  logic       irWrite;
  logic       mdrWrite;
  logic       pcWrite;
  logic [1:0] pcSrc;
  logic       regWrite;
  logic       retire;
  logic       halted;
  logic       fault;
  logic [2:0] state;

  modport master (
    input  opcode, zero, memAck,
    output memReq, memWe, addrSel, irWrite, mdrWrite, pcWrite, pcSrc,
           regWrite, retire, halted, fault, state
  );

  modport slave (
    output opcode, zero, memAck,
    input  memReq, memWe, addrSel, irWrite, mdrWrite, pcWrite, pcSrc,
           regWrite, retire, halted, fault, state
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle sequencer for the 16-bit core: walks fetch/decode/exec/mem/wb,
// issues datapath strobes and watches the shared memory port for ack timeouts.
module cpu_sequencer #(
  parameter int TIMEOUT = 15
) (
  input logic             clk,
  input logic             rst,
  cpu_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    FAULT  = 3'd6
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT - 1);
  localparam logic [3:0] OP_LDW    = 4'hA;
  localparam logic [3:0] OP_STW    = 4'hB;
  localparam logic [3:0] OP_BRZ    = 4'hC;
  localparam logic [3:0] OP_JAL    = 4'hD;

  state_t     cur;
  logic [7:0] wait_cnt;
  logic       is_store;

  // The wait counter idles at zero and only climbs during unacknowledged requests;
  // the store flag is captured in EXEC so later opcode changes cannot affect MEM.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur      <= FETCH;
      wait_cnt <= '0;
      is_store <= 1'b0;
    end else begin
      wait_cnt <= '0;
      case (cur)
        FETCH: begin
          if (bus.memAck)
            cur <= DECODE;
          else if (wait_cnt == LAST_WAIT)
            cur <= FAULT;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        DECODE: cur <= EXEC;
        EXEC: begin
          is_store <= (bus.opcode == OP_STW);
          if (bus.opcode <= 4'd9)
            cur <= WB;
          else if (bus.opcode == OP_LDW || bus.opcode == OP_STW)
            cur <= MEM;
          else if (bus.opcode == OP_BRZ || bus.opcode == OP_JAL)
            cur <= FETCH;
          else
            cur <= HALT;
        end
        MEM: begin
          if (bus.memAck)
            cur <= is_store ? FETCH : WB;
          else if (wait_cnt == LAST_WAIT)
            cur <= FAULT;
          else
            wait_cnt <= wait_cnt + 8'd1;
        end
        WB:      cur <= FETCH;
        HALT:    cur <= HALT;
        FAULT:   cur <= FAULT;
        default: cur <= FAULT;
      endcase
    end
  end

  logic       ir_write;
  logic       mdr_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       reg_write;
  logic       retire_pulse;

  // Ack- and opcode-qualified strobes must land in the same cycle as their cause.
  always_comb begin
    ir_write     = 1'b0;
    mdr_write    = 1'b0;
    pc_write     = 1'b0;
    pc_src       = 2'b00;
    reg_write    = 1'b0;
    retire_pulse = 1'b0;
    if (!rst) begin
      case (cur)
        FETCH: begin
          if (bus.memAck) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
          end
        end
        EXEC: begin
          if (bus.opcode == OP_BRZ) begin
            pc_write     = bus.zero;
            pc_src       = bus.zero ? 2'b01 : 2'b00;
            retire_pulse = 1'b1;
          end else if (bus.opcode == OP_JAL) begin
            reg_write    = 1'b1;
            pc_write     = 1'b1;
            pc_src       = 2'b10;
            retire_pulse = 1'b1;
          end
        end
        MEM: begin
          if (bus.memAck) begin
            if (is_store)
              retire_pulse = 1'b1;
            else
              mdr_write = 1'b1;
          end
        end
        WB: begin
          reg_write    = 1'b1;
          retire_pulse = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.irWrite  = ir_write;
  assign bus.mdrWrite = mdr_write;
  assign bus.pcWrite  = pc_write;
  assign bus.pcSrc    = pc_src;
  assign bus.regWrite = reg_write;
  assign bus.retire   = retire_pulse;

  // Moore outputs are forced quiet while reset is held, whatever the old state was.
  assign bus.memReq  = !rst && (cur == FETCH || cur == MEM);
  assign bus.memWe   = !rst && (cur == MEM) && is_store;
  assign bus.addrSel = !rst && (cur == MEM);
  assign bus.halted  = !rst && (cur == HALT);
  assign bus.fault   = !rst && (cur == FAULT);
  assign bus.state   = rst ? 3'd0 : cur;

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Multi-cycle instruction sequencer for the 16-bit CPU core. It steps each instruction through fetch, decode, execute, memory and writeback phases. It generates the per-cycle datapath strobes: IR/PC/MDR load, PC source, memory request, address select and register write. It also owns the shared single-port memory handshake, including ack timeout detection. It sits between the opcode decoder (which supplies static ALU/mux selects) and the PC, IR, register file and memory port.

## Interface
- `TIMEOUT`, 15, max cycles `memReq` may stay high without `memAck` (legal 1..255)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, synchronous, active-high
- `opcode`  in  4  IR[15:12], valid from DECODE onward
- `zero`  in  1  ALU zero flag, sampled in EXEC
- `memAck`  in  1  memory completion; may be high in the same cycle as `memReq`
- `memReq`  out  1  memory access request
- `memWe`  out  1  write qualifier, valid only with `memReq`
- `addrSel`  out  1  0 = PC, 1 = ALU result
- `irWrite`  out  1  load IR from memory read data
- `mdrWrite`  out  1  load MDR from memory read data
- `pcWrite`  out  1  load PC
- `pcSrc`  out  2  00 = PC+1, 01 = branch target, 10 = jump target
- `regWrite`  out  1  register file write strobe
- `retire`  out  1  one-cycle pulse on the last cycle of each instruction
- `halted`  out  1  illegal opcode seen
- `fault`  out  1  memory timeout seen
- `state`  out  3  FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6

## Operation
- **FETCH**
  - `memReq`=1, `addrSel`=0, `memWe`=0.
  - On `memAck`: `irWrite`=1, `pcWrite`=1, `pcSrc`=00, go to DECODE.
  - Otherwise stay in FETCH.
- **DECODE**: no strobes; go to EXEC.
- **EXEC**, by opcode:
  - 0000–1001 (ALU, ADI, SWP): go to WB.
  - 1010 (LDW), 1011 (STW): go to MEM.
  - 1100 (BRZ): if `zero`, `pcWrite`=1 with `pcSrc`=01. Then `retire`=1, go to FETCH.
  - 1101 (JAL): `regWrite`=1 (link), `pcWrite`=1, `pcSrc`=10, `retire`=1, go to FETCH.
  - 1110, 1111: go to HALT. No strobes, no `retire`.
- **MEM**
  - `memReq`=1, `addrSel`=1, `memWe`=1 for STW only.
  - On `memAck`, LDW: `mdrWrite`=1, go to WB.
  - On `memAck`, STW: `retire`=1, go to FETCH.
- **WB**: `regWrite`=1, `retire`=1, go to FETCH.
- **HALT**: `halted`=1. Sticky until `rst`; all strobes 0.
- **FAULT**: `fault`=1. Sticky until `rst`; all strobes 0.
- **Timeout counter** (8-bit)
  - Cleared on entry to FETCH or MEM, and on `memAck`.
  - Increments each cycle `memReq`=1 and `memAck`=0.
  - When the count reaches `TIMEOUT` with no ack, the next state is FAULT.
  - An ack in the same cycle the count would reach `TIMEOUT` wins: normal transition, no fault.
- `memAck` outside FETCH/MEM is ignored.
- An opcode change outside DECODE/EXEC has no effect.

## Timing
- **Output decoding**
  - Moore outputs: `state`, `halted`, `fault`, `memReq`, `memWe`, `addrSel`.
  - Ack-qualified outputs are combinational in the same cycle: `irWrite`, `mdrWrite`, FETCH/MEM transitions.
- **Cycles per instruction with zero-wait memory**

  | Class | Cycles |
  |---|---|
  | ALU | 4 |
  | LDW | 5 |
  | STW | 4 |
  | BRZ | 3 |
  | JAL | 3 |

  Each memory wait cycle adds 1.
- **Reset**
  - `rst` high on a clock edge leaves `state`=FETCH.
  - While `rst` is high, every output is 0 and `state`=0.
  - Timeout counter is 0.
  - First `memReq` appears in the cycle after `rst` falls.
  - Reset mid-wait, or in HALT/FAULT, aborts and restarts at FETCH. No partial strobe is issued.
- **`memReq` behaviour**
  - Held continuously until ack; never drops mid-wait.
  - Deasserts in the cycle after an ack.
  - Back-to-back FETCH after a retire is legal.

## Test plan
- **Reset then ADD**
  - Stimulus: reset, then ADD (0000), ack same cycle.
  - Required: `state` sequence 0,1,2,4. `regWrite` and `retire` in cycle 4 only. `pcWrite`=1 with `pcSrc`=00 in cycle 1.
- **LDW with waits**
  - Stimulus: LDW, `memAck` delayed 3 cycles in MEM.
  - Required: `memReq` high 4 cycles with `addrSel`=1, `memWe`=0. `mdrWrite` in the ack cycle, then WB. Total 8 cycles.
- **BRZ both outcomes**
  - `zero`=1 → `pcWrite`=1, `pcSrc`=01 in EXEC.
  - `zero`=0 → `pcWrite`=0.
  - Both: `retire` in cycle 3.
- **JAL and STW**
  - JAL: `regWrite`, `pcWrite` and `pcSrc`=10 in one EXEC cycle.
  - STW: `memWe`=1 in MEM. `retire` on the ack cycle with no WB.
- **Illegal opcode**
  - Stimulus: opcode 1110, then hold 20 cycles with ack toggling.
  - Required: `state`=5, `halted`=1, `memReq`=0 throughout. Reset returns to FETCH.
- **Timeout**
  - No ack in FETCH with `TIMEOUT`=15 → FAULT after 15 request cycles, `fault`=1.
  - Ack on request cycle 15 → DECODE, no fault.
  - `rst` during the wait → FETCH, counter 0.
